// File: rtl/snvs_lp_zmk_pkg.sv
// Shared types and defaults for the SNVS LP zeroizable master key transfer logic.
package snvs_lp_zmk_pkg;

  localparam int ZMK_KEY_WIDTH  = 256;
  localparam int ZMK_WORD_WIDTH = 32;
  // Widest word the parity helper accepts; callers zero-extend narrower words.
  localparam int ZMK_PARITY_MAX = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } zmk_state_e;

  // Even parity: XOR of all bits, so zero padding does not change the result.
  function automatic logic zmk_parity(input logic [ZMK_PARITY_MAX-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/snvs_lp_zmk_key_xfer.sv
// Streams the ZMK flip-flop bank out word by word over a valid/ready interface;
// only the word being presented is ever registered, and zeroize aborts at once.
module snvs_lp_zmk_key_xfer
  import snvs_lp_zmk_pkg::*;
#(
  parameter  int KEY_WIDTH  = ZMK_KEY_WIDTH,
  parameter  int WORD_WIDTH = ZMK_WORD_WIDTH,
  localparam int NUM_WORDS  = KEY_WIDTH / WORD_WIDTH,
  localparam int IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_b,
  input  logic [KEY_WIDTH-1:0]  i_zmk_key,
  input  logic                  i_zmk_valid,
  input  logic                  i_zeroize,
  input  logic                  i_xfer_req,
  output logic [WORD_WIDTH-1:0] o_key_word,
  output logic                  o_key_word_parity,
  output logic [IDX_WIDTH-1:0]  o_key_word_index,
  output logic                  o_key_word_last,
  output logic                  o_key_word_valid,
  input  logic                  i_key_word_ready,
  output logic                  o_xfer_busy,
  output logic                  o_xfer_done,
  output logic                  o_xfer_error
);

  zmk_state_e r_state;
  zmk_state_e w_stateNext;

  logic [WORD_WIDTH-1:0] r_keyWord;
  logic                  r_parity;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [WORD_WIDTH-1:0]     w_wordNext;
  logic                      w_parityNext;
  logic [IDX_WIDTH-1:0]      w_idxNext;
  logic                      w_lastNext;
  logic                      w_validNext;
  logic                      w_busyNext;
  logic                      w_doneNext;
  logic                      w_errorNext;
  logic [IDX_WIDTH-1:0]      w_idxInc;
  logic [ZMK_PARITY_MAX-1:0] w_parIn;
  logic [WORD_WIDTH-1:0]     w_words [NUM_WORDS];

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
    assign w_words[g] = i_zmk_key[g*WORD_WIDTH +: WORD_WIDTH];
  end

  assign w_idxInc = r_idx + IDX_WIDTH'(1);

  always_ff @(posedge i_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_state   <= IDLE;
      r_keyWord <= '0;
      r_parity  <= 1'b0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_keyWord <= w_wordNext;
      r_parity  <= w_parityNext;
      r_idx     <= w_idxNext;
      r_last    <= w_lastNext;
      r_valid   <= w_validNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_error   <= w_errorNext;
    end
  end

  // Loss of the key (zeroize or zmk_valid low) outranks the handshake in SEND.
  always_comb begin
    w_stateNext = r_state;
    w_wordNext  = r_keyWord;
    w_idxNext   = r_idx;
    w_lastNext  = r_last;
    w_validNext = r_valid;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    w_errorNext = 1'b0;
    w_parIn     = '0;

    case (r_state)
      IDLE: begin
        if (i_xfer_req) begin
          if (i_zmk_valid && !i_zeroize) begin
            w_stateNext = SEND;
            w_wordNext  = w_words[0];
            w_idxNext   = '0;
            w_lastNext  = (NUM_WORDS == 1);
            w_validNext = 1'b1;
            w_busyNext  = 1'b1;
          end else begin
            w_errorNext = 1'b1;
          end
        end
      end
      SEND: begin
        if (i_zeroize || !i_zmk_valid) begin
          w_stateNext = IDLE;
          w_wordNext  = '0;
          w_idxNext   = '0;
          w_lastNext  = 1'b0;
          w_validNext = 1'b0;
          w_busyNext  = 1'b0;
          w_errorNext = 1'b1;
        end else if (i_key_word_ready) begin
          if (r_last) begin
            w_stateNext = DONE;
            w_wordNext  = '0;
            w_idxNext   = '0;
            w_lastNext  = 1'b0;
            w_validNext = 1'b0;
            w_busyNext  = 1'b0;
            w_doneNext  = 1'b1;
          end else begin
            w_wordNext = w_words[w_idxInc];
            w_idxNext  = w_idxInc;
            w_lastNext = (w_idxInc == IDX_WIDTH'(NUM_WORDS - 1));
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_wordNext  = '0;
        w_idxNext   = '0;
        w_lastNext  = 1'b0;
        w_validNext = 1'b0;
        w_busyNext  = 1'b0;
      end
    endcase

    w_parIn[WORD_WIDTH-1:0] = w_wordNext;
    w_parityNext            = zmk_parity(w_parIn);
  end

  assign o_key_word        = r_keyWord;
  assign o_key_word_parity = r_parity;
  assign o_key_word_index  = r_idx;
  assign o_key_word_last   = r_last;
  assign o_key_word_valid  = r_valid;
  assign o_xfer_busy       = r_busy;
  assign o_xfer_done       = r_done;
  assign o_xfer_error      = r_error;

endmodule

// File: doc/snvs_lp_zmk_key_xfer.md
Name: snvs_lp_zmk_key_xfer

Overview:
Transmit side of the zeroizable master key (ZMK) storage in the SNVS LP domain. On request, it reads the ZMK flip-flop bank word by word and delivers the key to the consumer (HP-side key bus, crypto engine) over a valid/ready word interface with parity. Zeroization aborts any transfer immediately and scrubs the output register. The block never holds a full shadow copy of the key; only the single word currently being presented is registered.

Parameters:
KEY_WIDTH, 256, ZMK width in bits; must be a multiple of WORD_WIDTH.
WORD_WIDTH, 32, width of one transferred key word.
NUM_WORDS, KEY_WIDTH/WORD_WIDTH, derived, not overridable.
IDX_WIDTH, clog2(NUM_WORDS), derived word-index width.

Ports:
clock  input  1  block clock
reset_b  input  1  asynchronous active-low reset
zmk_key  input  KEY_WIDTH  parallel outputs of the ZMK FF bank
zmk_valid  input  1  ZMK programmed and not zeroized
zeroize  input  1  level; zeroization in progress (synchronous to clock)
xfer_req  input  1  single-cycle pulse requesting a full key transfer
key_word  output  WORD_WIDTH  current key word; all zeros when key_word_valid=0
key_word_parity  output  1  even parity over key_word
key_word_index  output  IDX_WIDTH  index of current word
key_word_last  output  1  current word is index NUM_WORDS-1
key_word_valid  output  1  word presented
key_word_ready  input  1  consumer accepts word
xfer_busy  output  1  transfer in progress
xfer_done  output  1  one-cycle pulse after last word accepted
xfer_error  output  1  one-cycle pulse: refused request or aborted transfer

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_b).
- Reset: all outputs 0; state IDLE; index 0.
- FSM states: IDLE, SEND, DONE.
- IDLE: xfer_req=1 with zmk_valid=1 and zeroize=0 -> SEND on the next edge; key_word is loaded with zmk_key[WORD_WIDTH-1:0], index=0, key_word_valid=1, xfer_busy=1. Latency from request to first valid is 1 cycle.
- IDLE: xfer_req=1 with zmk_valid=0 or zeroize=1 -> remain in IDLE; xfer_error pulses for 1 cycle.
- SEND: key_word, parity, index and last are held stable while key_word_valid=1 and key_word_ready=0.
- SEND: on valid&ready with last=0, the next word zmk_key[(i+1)*WORD_WIDTH +: WORD_WIDTH] is registered on the same edge. Throughput is one word per cycle, with no bubbles.
- SEND: on valid&ready with last=1 -> DONE. key_word is cleared to 0 and valid=0 on that edge.
- DONE: xfer_done=1 for exactly 1 cycle, xfer_busy=0 -> IDLE. A xfer_req arriving in DONE is ignored (no error).
- xfer_req while busy (SEND) is ignored, with no error and no restart.
- Word order is little-endian: word 0 = zmk_key[WORD_WIDTH-1:0]. Index increments by 1 and never wraps within a transfer.
- Key sampling: each word is sampled from zmk_key when loaded. The block does not snapshot the key at request time.
- Zeroize priority: zeroize=1 or zmk_valid falling (zmk_valid=0) in SEND overrides the handshake on the same edge. key_word, parity and index are cleared to 0, valid=0, busy=0, state goes to IDLE, xfer_error pulses, and xfer_done does not assert.
- Zeroize in IDLE or DONE: no error; the transition from DONE to IDLE is still taken.
- key_word_parity is the XOR of the registered key_word and is registered in the same cycle as key_word. It is 0 when idle.
- An async reset mid-transfer returns the block to reset values immediately, with no done or error pulse.

Decomposition:
- Package snvs_lp_zmk_pkg holds the FSM state enum (IDLE/SEND/DONE), ZMK_KEY_WIDTH=256 and ZMK_WORD_WIDTH=32 defaults, and a parity function.
- No sub-module. The word select is an indexed part-select inside the block; a separate mux module would only add a key-bearing boundary.

Test Plan:
- Key = 256'h0123..EF (distinct words), ready held 1, pulse xfer_req -> valid from cycle+1; words 0..7 in 8 consecutive cycles with index 0..7; last only on index 7; done pulses the cycle after; parity matches each word.
- Ready toggles 1,0,0,1 -> each word is held stable through the stalls; the 8 words arrive in order; busy stays high until DONE.
- zmk_valid=0 with xfer_req pulse -> xfer_error pulses 1 cycle; valid and busy stay 0; key_word stays 0.
- Zeroize asserted after word 3 is accepted (index=4 presented) -> the next edge gives key_word=0, valid=0, busy=0, error=1, with no done pulse; a later request after zeroize drops and zmk_valid=1 restarts from index 0.
- Second xfer_req during SEND (index 2) -> ignored: no error, sequence continues to index 7, a single done pulse.
- reset_b low mid-transfer (index 5) -> all outputs are 0 asynchronously, before the next clock edge; after release the block is in IDLE with no pulses.
